// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master that serialises a valid/ready word stream onto mosi
// and returns the miso word on a one-cycle rx_valid pulse. Optional macro: SPI_MASTER_LSB_FIRST_EN.
module spi_master #(
  parameter int IODepth = 8,
  parameter int CLK_DIV = 4
) (
  input  logic               fclk,
  input  logic               rst_n,
  input  logic [IODepth-1:0] tx_dat,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [IODepth-1:0] rx_dat,
  output logic               rx_valid,
  output logic               busy,
  output logic               sck,
  output logic               css,
  output logic               mosi,
  input  logic               miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (IODepth > 1) ? $clog2(IODepth) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(IODepth - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TAIL,
    S_GAP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [DIV_W-1:0]     w_div_nxt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [IODepth-1:0]   r_tx_sr;
  logic [IODepth-1:0]   w_tx_sr_nxt;
  logic [IODepth-1:0]   r_rx_sr;
  logic [IODepth-1:0]   w_rx_sr_nxt;
  logic [IODepth-1:0]   r_rx_dat;
  logic [IODepth-1:0]   w_rx_dat_nxt;
  logic                 r_rx_valid;
  logic                 w_rx_valid_nxt;
  logic                 r_sck;
  logic                 w_sck_nxt;
  logic                 r_css;
  logic                 w_css_nxt;
  logic                 w_tx_ready;
  logic                 w_busy;
  logic                 w_div_last;
  logic                 w_bit_last;
  logic [IODepth-1:0]   w_tx_shift;
  logic [IODepth-1:0]   w_rx_shift;

  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign w_bit_last = (r_bit_cnt == BIT_LAST);

  // mosi is the outgoing end of the tx shift register, so it moves only when the register does.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_tx_shift = {1'b0, r_tx_sr[IODepth-1:1]};
  assign w_rx_shift = {miso, r_rx_sr[IODepth-1:1]};
  assign mosi       = r_tx_sr[0];
`else
  assign w_tx_shift = {r_tx_sr[IODepth-2:0], 1'b0};
  assign w_rx_shift = {r_rx_sr[IODepth-2:0], miso};
  assign mosi       = r_tx_sr[IODepth-1];
`endif

  always_comb begin
    // NOTE: every signal driven here is defaulted first, so no branch can infer a latch.
    w_state_nxt    = r_state;
    w_div_nxt      = w_div_last ? '0 : r_div_cnt + DIV_W'(1);
    w_bit_nxt      = r_bit_cnt;
    w_tx_sr_nxt    = r_tx_sr;
    w_rx_sr_nxt    = r_rx_sr;
    w_rx_dat_nxt   = r_rx_dat;
    w_rx_valid_nxt = 1'b0;
    w_sck_nxt      = r_sck;
    w_css_nxt      = r_css;
    w_tx_ready     = 1'b0;
    w_busy         = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_tx_ready = 1'b1;
        w_busy     = 1'b0;
        w_div_nxt  = '0;
        if (tx_valid) begin
          w_tx_sr_nxt = tx_dat;
          w_bit_nxt   = '0;
          w_css_nxt   = 1'b1;
          w_state_nxt = S_LEAD;
        end
      end

      S_LEAD: begin
        if (w_div_last) begin
          w_sck_nxt   = 1'b1;
          w_rx_sr_nxt = w_rx_shift;
          w_state_nxt = S_HIGH;
        end
      end

      S_HIGH: begin
        // The last cycle of the last HIGH phase is the handshake slot for a back-to-back word.
        w_tx_ready = w_div_last && w_bit_last;
        if (w_div_last) begin
          w_sck_nxt = 1'b0;
          if (!w_bit_last) begin
            w_tx_sr_nxt = w_tx_shift;
            w_bit_nxt   = r_bit_cnt + BIT_W'(1);
            w_state_nxt = S_LOW;
          end else begin
            w_rx_dat_nxt   = r_rx_sr;
            w_rx_valid_nxt = 1'b1;
            if (tx_valid) begin
              w_tx_sr_nxt = tx_dat;
              w_bit_nxt   = '0;
              w_state_nxt = S_LOW;
            end else begin
              w_state_nxt = S_TAIL;
            end
          end
        end
      end

      S_LOW: begin
        if (w_div_last) begin
          w_sck_nxt   = 1'b1;
          w_rx_sr_nxt = w_rx_shift;
          w_state_nxt = S_HIGH;
        end
      end

      S_TAIL: begin
        if (w_div_last) begin
          w_css_nxt   = 1'b0;
          w_state_nxt = S_GAP;
        end
      end

      // css stays low for a full phase so the peer's bit counter is cleared before the next word.
      S_GAP: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_dat   <= '0;
      r_rx_valid <= 1'b0;
      r_sck      <= 1'b0;
      r_css      <= 1'b0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_tx_sr    <= w_tx_sr_nxt;
      r_rx_sr    <= w_rx_sr_nxt;
      r_rx_dat   <= w_rx_dat_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_sck      <= w_sck_nxt;
      r_css      <= w_css_nxt;
    end
  end

  assign tx_ready = w_tx_ready;
  assign busy     = w_busy;
  assign sck      = r_sck;
  assign css      = r_css;
  assign rx_dat   = r_rx_dat;
  assign rx_valid = r_rx_valid;

endmodule
